// File: rtl/rob_param_if.sv
// Reorder-buffer port bundle: dispatch, CDB writeback, operand lookup and commit.
// master = core side driving requests, slave = the reorder buffer.
interface rob_param_if #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NUM_CDB = 2,
    parameter int unsigned XLEN    = 32
);
    localparam int unsigned TAG_W = $clog2(DEPTH);

    logic                      flush;
    logic                      dispatch_valid;
    logic [4:0]                dispatch_rd;
    logic                      dispatch_ready;
    logic [TAG_W-1:0]          dispatch_tag;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*XLEN-1:0]   cdb_data;
    logic [TAG_W-1:0]          rob_tag1;
    logic [TAG_W-1:0]          rob_tag2;
    logic                      rob_v1;
    logic                      rob_v2;
    logic [XLEN-1:0]           src1;
    logic [XLEN-1:0]           src2;
    logic                      commit_valid;
    logic [4:0]                commit_rd;
    logic [XLEN-1:0]           commit_data;
    logic [TAG_W-1:0]          commit_tag;
    logic                      rob_empty;
    logic [31:0]               full_stall_cycles;

    modport master (
        output flush, dispatch_valid, dispatch_rd, cdb_valid, cdb_tag, cdb_data,
               rob_tag1, rob_tag2,
        input  dispatch_ready, dispatch_tag, rob_v1, rob_v2, src1, src2,
               commit_valid, commit_rd, commit_data, commit_tag, rob_empty,
               full_stall_cycles
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_rd, cdb_valid, cdb_tag, cdb_data,
               rob_tag1, rob_tag2,
        output dispatch_ready, dispatch_tag, rob_v1, rob_v2, src1, src2,
               commit_valid, commit_rd, commit_data, commit_tag, rob_empty,
               full_stall_cycles
    );
endinterface

// File: rtl/rob_param.sv
// Parametrised circular reorder buffer with in-order dispatch/commit and CDB writeback by tag.
// Optional full-stall counter enabled by defining ROB_STALL_STATS_EN.
module rob_param #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NUM_CDB = 2,
    parameter int unsigned XLEN    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    rob_param_if.slave    bus
);
    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             busy_q  [DEPTH];
    logic             ready_q [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [XLEN-1:0]  data_q  [DEPTH];
    logic [TAG_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic             wb_hit  [DEPTH];
    logic [XLEN-1:0]  wb_data [DEPTH];
    logic [TAG_W-1:0] cdb_tag_a  [NUM_CDB];
    logic [XLEN-1:0]  cdb_data_a [NUM_CDB];

    logic dispatch_fire;
    logic commit_fire;

    assign bus.dispatch_ready = (count_q != CNT_W'(DEPTH));
    assign bus.dispatch_tag   = tail_q;
    assign bus.rob_empty      = (count_q == '0);
    assign dispatch_fire      = bus.dispatch_valid && bus.dispatch_ready && !bus.flush;
    assign commit_fire        = busy_q[head_q] && ready_q[head_q] && !bus.flush;

    assign bus.commit_valid = commit_fire;
    assign bus.commit_rd    = commit_fire ? rd_q[head_q]   : '0;
    assign bus.commit_data  = commit_fire ? data_q[head_q] : '0;
    assign bus.commit_tag   = commit_fire ? head_q         : '0;

    for (genvar p = 0; p < NUM_CDB; p++) begin : g_cdb
        assign cdb_tag_a[p]  = bus.cdb_tag[p*TAG_W +: TAG_W];
        assign cdb_data_a[p] = bus.cdb_data[p*XLEN +: XLEN];
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        logic [NUM_CDB-1:0] match;
        logic [XLEN-1:0]    chain [NUM_CDB+1];

        // Priority chain so the lowest-index matching port supplies the data.
        assign chain[NUM_CDB] = '0;
        for (genvar p = 0; p < NUM_CDB; p++) begin : g_port
            assign match[p] = bus.cdb_valid[p] && (cdb_tag_a[p] == TAG_W'(e)) && busy_q[e];
            assign chain[p] = match[p] ? cdb_data_a[p] : chain[p+1];
        end
        assign wb_hit[e]  = |match;
        assign wb_data[e] = chain[0];

        // Commit and dispatch never target the same entry: that would need head==tail with count in (0,DEPTH).
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                busy_q[e]  <= 1'b0;
                ready_q[e] <= 1'b0;
                rd_q[e]    <= '0;
                data_q[e]  <= '0;
            end else if (bus.flush) begin
                busy_q[e]  <= 1'b0;
                ready_q[e] <= 1'b0;
            end else if (commit_fire && (head_q == TAG_W'(e))) begin
                busy_q[e]  <= 1'b0;
                ready_q[e] <= 1'b0;
            end else if (dispatch_fire && (tail_q == TAG_W'(e))) begin
                busy_q[e]  <= 1'b1;
                ready_q[e] <= 1'b0;
                rd_q[e]    <= bus.dispatch_rd;
            end else if (wb_hit[e]) begin
                ready_q[e] <= 1'b1;
                data_q[e]  <= wb_data[e];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (dispatch_fire && !commit_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!dispatch_fire && commit_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (dispatch_fire) tail_q <= tail_q + TAG_W'(1);
            if (commit_fire)   head_q <= head_q + TAG_W'(1);
            count_q <= count_d;
        end
    end

    // Stored result first, otherwise forward a same-cycle CDB broadcast to the busy entry.
    function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] t);
        logic [XLEN:0] r;
        r = '0;
        if (busy_q[t] && ready_q[t]) begin
            r = {1'b1, data_q[t]};
        end else if (wb_hit[t]) begin
            r = {1'b1, wb_data[t]};
        end
        return r;
    endfunction

    assign {bus.rob_v1, bus.src1} = lookup(bus.rob_tag1);
    assign {bus.rob_v2, bus.src2} = lookup(bus.rob_tag2);

`ifdef ROB_STALL_STATS_EN
    logic [31:0] stall_q;

    // Counts blocked dispatch attempts; survives flush, saturates at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (bus.dispatch_valid && !bus.dispatch_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end
    assign bus.full_stall_cycles = stall_q;
`else
    assign bus.full_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: directed scenarios then random traffic against a queue-based model.
module tb_rob_param;
    localparam int DEPTH   = 8;
    localparam int NUM_CDB = 2;
    localparam int XLEN    = 32;
    localparam int TAG_W   = $clog2(DEPTH);
`ifdef ROB_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rob_param_if #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) bus ();

    rob_param #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: in-flight instructions in program order; tag is allocation order modulo DEPTH.
    typedef struct {
        int              tag;
        logic [4:0]      rd;
        bit              rdy;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q[$];
    int              tail_m;
    longint unsigned stall_m;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        tail_m  = 0;
        stall_m = 0;
    endtask

    task automatic idle();
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.dispatch_rd    = '0;
        bus.cdb_valid      = '0;
        bus.cdb_tag        = '0;
        bus.cdb_data       = '0;
        bus.rob_tag1       = '0;
        bus.rob_tag2       = '0;
    endtask

    task automatic set_cdb(input int p, input int t, input logic [XLEN-1:0] d);
        bus.cdb_valid[p]              = 1'b1;
        bus.cdb_tag[p*TAG_W +: TAG_W] = TAG_W'(t);
        bus.cdb_data[p*XLEN +: XLEN]  = d;
    endtask

    function automatic void model_lookup(input int t, output bit v, output logic [XLEN-1:0] d);
        v = 1'b0;
        d = '0;
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].tag == t) begin
                if (q[k].rdy) begin
                    v = 1'b1;
                    d = q[k].data;
                end else begin
                    for (int p = NUM_CDB - 1; p >= 0; p--) begin
                        if (bus.cdb_valid[p] && int'(bus.cdb_tag[p*TAG_W +: TAG_W]) == t) begin
                            v = 1'b1;
                            d = bus.cdb_data[p*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    endfunction

    task automatic check_outputs();
        int              n;
        bit              cv;
        bit              v;
        logic [XLEN-1:0] d;
        logic [4:0]      erd;
        logic [XLEN-1:0] edata;
        int              etag;
        n     = q.size();
        cv    = (n > 0) && q[0].rdy && !bus.flush;
        erd   = '0;
        edata = '0;
        etag  = 0;
        if (cv) begin
            erd   = q[0].rd;
            edata = q[0].data;
            etag  = q[0].tag;
        end
        chk("dispatch_ready", 64'(bus.dispatch_ready), 64'(n != DEPTH));
        chk("dispatch_tag",   64'(bus.dispatch_tag),   64'(tail_m));
        chk("rob_empty",      64'(bus.rob_empty),      64'(n == 0));
        chk("commit_valid",   64'(bus.commit_valid),   64'(cv));
        chk("commit_rd",      64'(bus.commit_rd),      64'(erd));
        chk("commit_data",    64'(bus.commit_data),    64'(edata));
        chk("commit_tag",     64'(bus.commit_tag),     64'(etag));
        model_lookup(int'(bus.rob_tag1), v, d);
        chk("rob_v1", 64'(bus.rob_v1), 64'(v));
        chk("src1",   64'(bus.src1),   64'(d));
        model_lookup(int'(bus.rob_tag2), v, d);
        chk("rob_v2", 64'(bus.rob_v2), 64'(v));
        chk("src2",   64'(bus.src2),   64'(d));
        chk("full_stall_cycles", 64'(bus.full_stall_cycles), STATS ? 64'(stall_m) : 64'd0);
    endtask

    task automatic model_update(input bit fl, input bit dv, input logic [4:0] rd,
                                input logic [NUM_CDB-1:0] cvl,
                                input logic [NUM_CDB*TAG_W-1:0] ct,
                                input logic [NUM_CDB*XLEN-1:0] cd);
        int   n;
        bit   fire;
        bit   com;
        ent_t e;
        n    = q.size();
        fire = dv && (n != DEPTH) && !fl;
        com  = (n > 0) && q[0].rdy && !fl;
        if (STATS && dv && (n == DEPTH) && (stall_m != 64'hFFFF_FFFF)) stall_m++;
        if (fl) begin
            q.delete();
            tail_m = 0;
            return;
        end
        for (int k = 0; k < q.size(); k++) begin
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (cvl[p] && int'(ct[p*TAG_W +: TAG_W]) == q[k].tag) begin
                    e      = q[k];
                    e.rdy  = 1'b1;
                    e.data = cd[p*XLEN +: XLEN];
                    q[k]   = e;
                end
            end
        end
        if (com) void'(q.pop_front());
        if (fire) begin
            e.tag  = tail_m;
            e.rd   = rd;
            e.rdy  = 1'b0;
            e.data = '0;
            q.push_back(e);
            tail_m = (tail_m + 1) % DEPTH;
        end
    endtask

    // Entered at a negedge with inputs driven; checks, clocks, updates the model, returns at the next negedge.
    task automatic cycle();
        bit                       fl;
        bit                       dv;
        logic [4:0]               rd;
        logic [NUM_CDB-1:0]       cvl;
        logic [NUM_CDB*TAG_W-1:0] ct;
        logic [NUM_CDB*XLEN-1:0]  cd;
        #1;
        check_outputs();
        fl  = bus.flush;
        dv  = bus.dispatch_valid;
        rd  = bus.dispatch_rd;
        cvl = bus.cdb_valid;
        ct  = bus.cdb_tag;
        cd  = bus.cdb_data;
        @(posedge clk);
        model_update(fl, dv, rd, cvl, ct, cd);
        @(negedge clk);
    endtask

    task automatic sync_reset();
        idle();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_dispatch_ready", 64'(bus.dispatch_ready), 64'd1);
        chk("reset_rob_empty",      64'(bus.rob_empty),      64'd1);
        chk("reset_commit_valid",   64'(bus.commit_valid),   64'd0);
        chk("reset_dispatch_tag",   64'(bus.dispatch_tag),   64'd0);
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Three dispatches receive tags 0,1,2
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.dispatch_valid = 1'b1;
            bus.dispatch_rd    = 5'(i + 1);
            #1 chk("dispatch_seq_tag", 64'(bus.dispatch_tag), 64'(i));
            cycle();
        end
        idle();
        #1;
        chk("after3_rob_empty",    64'(bus.rob_empty),    64'd0);
        chk("after3_commit_valid", 64'(bus.commit_valid), 64'd0);
        cycle();

        // Bypass then stored value for tag1
        idle();
        set_cdb(0, 1, 32'hDEAD_BEEF);
        bus.rob_tag1 = TAG_W'(1);
        #1;
        chk("bypass_v1",        64'(bus.rob_v1),       64'd1);
        chk("bypass_src1",      64'(bus.src1),         64'hDEAD_BEEF);
        chk("bypass_no_commit", 64'(bus.commit_valid), 64'd0);
        cycle();
        idle();
        bus.rob_tag1 = TAG_W'(1);
        #1;
        chk("stored_v1",   64'(bus.rob_v1), 64'd1);
        chk("stored_src1", 64'(bus.src1),   64'hDEAD_BEEF);
        cycle();

        // Two-port writeback, then three in-order commits
        idle();
        set_cdb(0, 0, 32'd5);
        set_cdb(1, 2, 32'd7);
        #1 chk("wb_cycle_no_commit", 64'(bus.commit_valid), 64'd0);
        cycle();
        idle();
        #1;
        chk("commit0_valid", 64'(bus.commit_valid), 64'd1);
        chk("commit0_rd",    64'(bus.commit_rd),    64'd1);
        chk("commit0_data",  64'(bus.commit_data),  64'd5);
        cycle();
        idle();
        #1;
        chk("commit1_rd",   64'(bus.commit_rd),   64'd2);
        chk("commit1_data", 64'(bus.commit_data), 64'hDEAD_BEEF);
        cycle();
        idle();
        #1;
        chk("commit2_rd",   64'(bus.commit_rd),   64'd3);
        chk("commit2_data", 64'(bus.commit_data), 64'd7);
        cycle();
        idle();
        #1 chk("drained_rob_empty", 64'(bus.rob_empty), 64'd1);
        cycle();

        // Fill to DEPTH, ignored extra dispatch, wrap of the tail
        sync_reset();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            bus.dispatch_valid = 1'b1;
            bus.dispatch_rd    = 5'(i + 1);
            cycle();
        end
        idle();
        bus.dispatch_valid = 1'b1;
        bus.dispatch_rd    = 5'd9;
        #1 chk("full_dispatch_ready", 64'(bus.dispatch_ready), 64'd0);
        cycle();
        idle();
        #1 chk("full_stall_count", 64'(bus.full_stall_cycles), STATS ? 64'd1 : 64'd0);
        set_cdb(0, 0, 32'h1234);
        cycle();
        idle();
        #1;
        chk("wrap_commit_valid", 64'(bus.commit_valid), 64'd1);
        chk("wrap_commit_tag",   64'(bus.commit_tag),   64'd0);
        chk("wrap_commit_rd",    64'(bus.commit_rd),    64'd1);
        cycle();
        idle();
        bus.dispatch_valid = 1'b1;
        bus.dispatch_rd    = 5'd10;
        #1;
        chk("wrap_dispatch_ready", 64'(bus.dispatch_ready), 64'd1);
        chk("wrap_dispatch_tag",   64'(bus.dispatch_tag),   64'd0);
        cycle();

        // Same tag on both ports: port 0 wins
        idle();
        set_cdb(0, 3, 32'd11);
        set_cdb(1, 3, 32'd22);
        cycle();
        idle();
        bus.rob_tag2 = TAG_W'(3);
        #1;
        chk("prio_v2",   64'(bus.rob_v2), 64'd1);
        chk("prio_src2", 64'(bus.src2),   64'd11);
        cycle();

        // Flush with five in flight and concurrent dispatch/writeback
        idle();
        bus.flush = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            idle();
            bus.dispatch_valid = 1'b1;
            bus.dispatch_rd    = 5'(20 + i);
            cycle();
        end
        idle();
        set_cdb(0, 0, 32'd99);
        cycle();
        idle();
        bus.flush          = 1'b1;
        bus.dispatch_valid = 1'b1;
        bus.dispatch_rd    = 5'd7;
        set_cdb(1, 2, 32'd55);
        #1 chk("flush_commit_forced_0", 64'(bus.commit_valid), 64'd0);
        cycle();
        idle();
        bus.rob_tag1 = TAG_W'(2);
        bus.rob_tag2 = TAG_W'(0);
        #1;
        chk("post_flush_empty", 64'(bus.rob_empty),    64'd1);
        chk("post_flush_tag",   64'(bus.dispatch_tag), 64'd0);
        chk("post_flush_v1",    64'(bus.rob_v1),       64'd0);
        chk("post_flush_v2",    64'(bus.rob_v2),       64'd0);
        cycle();

        // Random traffic with an asynchronous reset in the middle
        for (int c = 0; c < 400; c++) begin
            idle();
            bus.flush          = ($urandom_range(0, 39) == 0);
            bus.dispatch_valid = ($urandom_range(0, 9) < 6);
            bus.dispatch_rd    = 5'($urandom);
            for (int p = 0; p < NUM_CDB; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int t;
                    if (q.size() > 0 && $urandom_range(0, 4) != 0)
                        t = q[$urandom_range(0, q.size() - 1)].tag;
                    else
                        t = $urandom_range(0, DEPTH - 1);
                    set_cdb(p, t, XLEN'($urandom));
                end
            end
            bus.rob_tag1 = TAG_W'($urandom);
            bus.rob_tag2 = TAG_W'($urandom);
            if (c == 200) begin
                #2 reset_n = 1'b0;
                model_reset();
                #1;
                chk("async_rst_ready", 64'(bus.dispatch_ready), 64'd1);
                chk("async_rst_empty", 64'(bus.rob_empty),      64'd1);
                chk("async_rst_tag",   64'(bus.dispatch_tag),   64'd0);
                check_outputs();
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
